// File: rtl/weight_sram_pkg.sv
// ---------------------------------------------------------------------------
// weight_sram_pkg
//   Shared constants and types for the weight SRAM controller.
//   ADDR_W / DATA_W / DEPTH describe the 32x30 weight SRAM macro.
//   state_e is the controller sequencing state.
// ---------------------------------------------------------------------------
package weight_sram_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 30;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_e;

endpackage

// File: rtl/weight_sram_ctrl.sv
// ---------------------------------------------------------------------------
// weight_sram_ctrl
//   Arbiter/sequencer for the single-port weight SRAM (1-cycle registered read).
//   The host loader writes single words while the controller is IDLE. The
//   compute engine requests read bursts of rd_len words starting at rd_base,
//   with addresses wrapping mod DEPTH. Returned words are tagged with
//   rd_valid/rd_last so the engine never deals with SRAM timing.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data   loader write handshake
//   rd_start/rd_base/rd_len         burst request (sampled in IDLE only)
//   busy                            burst in progress (STREAM or DRAIN)
//   rd_valid/rd_data/rd_last        burst return stream, no backpressure
//   done                            1-cycle pulse after the rd_last beat
//   sram_ceb/web/a/d                registered SRAM command (active-low enables)
//   sram_q                          SRAM read data, 1 clk after a read command
// ---------------------------------------------------------------------------
module weight_sram_ctrl
    import weight_sram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W:0]   rd_len,
    output logic              busy,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

    state_e              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                ceb_q, ceb_d;
    logic                web_q, web_d;
    logic [ADDR_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   d_q, d_d;
    // iss_* marks a read command sitting on the SRAM pins this cycle; the
    // word it fetches shows up one cycle later, so rd_valid/rd_last are
    // simply these flags delayed by one register.
    logic                iss_q, iss_d;
    logic                iss_last_q, iss_last_d;
    logic                rd_valid_q;
    logic                rd_last_q;
    logic                done_q, done_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        ceb_d      = 1'b1;
        web_d      = 1'b1;
        a_d        = a_q;
        d_d        = d_q;
        iss_d      = 1'b0;
        iss_last_d = 1'b0;
        done_d     = 1'b0;
        wr_ready   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A burst request always wins the port, even when it is
                // about to be ignored for a zero length.
                wr_ready = ~rd_start;
                if (rd_start && (rd_len != '0)) begin
                    state_d = STREAM;
                    cnt_d   = (rd_len > LEN_MAX) ? LEN_MAX : rd_len;
                    addr_d  = rd_base;
                end else if (wr_valid && !rd_start) begin
                    ceb_d = 1'b0;
                    web_d = 1'b0;
                    a_d   = wr_addr;
                    d_d   = wr_data;
                end
            end
            STREAM: begin
                ceb_d      = 1'b0;
                a_d        = addr_q;
                addr_d     = addr_q + 1'b1;   // natural wrap: DEPTH == 2**ADDR_W
                cnt_d      = cnt_q - 1'b1;
                iss_d      = 1'b1;
                iss_last_d = (cnt_q == LEN_ONE);
                if (cnt_q == LEN_ONE) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave once the final word is on rd_data; done follows.
                if (rd_last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            ceb_q      <= 1'b1;
            web_q      <= 1'b1;
            a_q        <= '0;
            d_q        <= '0;
            iss_q      <= 1'b0;
            iss_last_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            ceb_q      <= ceb_d;
            web_q      <= web_d;
            a_q        <= a_d;
            d_q        <= d_d;
            iss_q      <= iss_d;
            iss_last_q <= iss_last_d;
            rd_valid_q <= iss_q;
            rd_last_q  <= iss_last_q;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign rd_data  = rd_valid_q ? sram_q : '0;
    assign done     = done_q;
    assign sram_ceb = ceb_q;
    assign sram_web = web_q;
    assign sram_a   = a_q;
    assign sram_d   = d_q;

endmodule
